pipeline_mem_stage: RTL and testbench

Memory-access stage of the 5-stage pcpu pipeline, sitting between the EX/MEM register and the write-back stage.
- Issues loads/stores to data memory over a req/ack bus and stalls upstream while memory is busy.
- Aligns and sign/zero-extends load data, and generates store byte enables.
- Contains the MEM/WB pipeline register that feeds write-back with PC+4, ALU result, load data and MemtoReg select.

---
 rtl/pcpu.sv | 44 ++++
 rtl/load_align.sv | 29 ++
 rtl/pipeline_mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_mem_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu.sv
// Shared pcpu pipeline types: debug bundle, memory access widths, MEM-stage FSM states
// and the store lane helpers used by the memory-access stage.
package pcpu;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } Debug_t;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } MemWidth_t;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } MemState_t;

    // Halfwords always use lane 0 or 2; the low address bit is not honoured.
    function automatic logic [3:0] store_be(input logic [1:0] width, input logic [1:0] lane);
        logic [3:0] be;
        case (width)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] width, input logic [31:0] rs2);
        logic [31:0] data;
        case (width)
            2'b00:   data = {4{rs2[7:0]}};
            2'b01:   data = {2{rs2[15:0]}};
            default: data = rs2;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed byte/halfword of a raw read word and
// sign- or zero-extends it according to the access width.
module load_align
    import pcpu::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction and extension per access width
    always_comb begin
        byte_s = rdata[{lane, 3'b000} +: 8];
        half_s = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            MEM_B:   data = {{24{byte_s[7]}}, byte_s};
            MEM_BU:  data = {24'h000000, byte_s};
            MEM_H:   data = {{16{half_s[15]}}, half_s};
            MEM_HU:  data = {16'h0000, half_s};
            MEM_W:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_stage.sv
// pcpu MEM stage: data-memory req/ack access with upstream stall, load alignment and the
// MEM/WB register. Define MEM_ALIGN_CHECK_EN to trap misaligned H/W accesses (misalign_WB).
module pipeline_mem_stage
    import pcpu::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in_MEM,
    input  Debug_t      debug_in_MEM,
    input  logic [31:0] PC4_in_MEM,
    input  logic [31:0] ALU_in_MEM,
    input  logic [31:0] Data_in_MEM,
    input  logic        MemRead_in_MEM,
    input  logic        MemWrite_in_MEM,
    input  logic [2:0]  Funct3_in_MEM,
    input  logic [1:0]  MemtoReg_in_MEM,
    input  logic        RegWrite_in_MEM,
    input  logic [4:0]  Rd_in_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_MEM,
    output logic        valid_out_WB,
    output logic        RegWrite_out_WB,
    output Debug_t      debug_out_WB,
    output logic [31:0] PC4_out_WB,
    output logic [31:0] ALU_out_WB,
    output logic [31:0] DMem_data_WB,
    output logic [1:0]  MemtoReg_out_WB,
    output logic [4:0]  Rd_out_WB,
    output logic [31:0] stall_cycles
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign_WB
`endif
);

    MemState_t   state_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;
    logic        we_r;
    logic [2:0]  funct3_r;

    logic        mem_op_s;
    logic        misalign_s;
    logic        req_op_s;
    logic        req_s;
    logic        stall_s;
    logic [31:0] in_wdata_s;
    logic [3:0]  in_be_s;
    logic [1:0]  ld_lane_s;
    logic [2:0]  ld_funct3_s;
    logic [31:0] ld_data_s;

    // Decode of the incoming instruction's memory request
    always_comb begin
        mem_op_s = valid_in_MEM & (MemRead_in_MEM | MemWrite_in_MEM);
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s = mem_op_s &
                     ((((Funct3_in_MEM == MEM_H) || (Funct3_in_MEM == MEM_HU)) && ALU_in_MEM[0]) ||
                      ((Funct3_in_MEM == MEM_W) && (ALU_in_MEM[1:0] != 2'b00)));
`else
        misalign_s = 1'b0;
`endif
        req_op_s   = mem_op_s & ~misalign_s;
        in_wdata_s = store_data(Funct3_in_MEM[1:0], Data_in_MEM);
        in_be_s    = MemWrite_in_MEM ? store_be(Funct3_in_MEM[1:0], ALU_in_MEM[1:0]) : 4'b1111;
    end

    // Bus drive: straight from the inputs in IDLE, from the latched request in WAIT
    always_comb begin
        if (state_r == MEM_WAIT) begin
            req_s       = 1'b1;
            dmem_we     = we_r;
            dmem_addr   = {addr_r[31:2], 2'b00};
            dmem_wdata  = wdata_r;
            dmem_be     = be_r;
            stall_s     = ~dmem_ack;
            ld_lane_s   = addr_r[1:0];
            ld_funct3_s = funct3_r;
        end else begin
            req_s       = req_op_s;
            dmem_we     = MemWrite_in_MEM;
            dmem_addr   = {ALU_in_MEM[31:2], 2'b00};
            dmem_wdata  = in_wdata_s;
            dmem_be     = in_be_s;
            stall_s     = req_op_s & ~dmem_ack;
            ld_lane_s   = ALU_in_MEM[1:0];
            ld_funct3_s = Funct3_in_MEM;
        end
        dmem_req  = req_s & ~rst;
        stall_MEM = stall_s & ~rst;
    end

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .lane   (ld_lane_s),
        .funct3 (ld_funct3_s),
        .data   (ld_data_s)
    );

    // Access FSM and request latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= MEM_IDLE;
            addr_r   <= 32'h00000000;
            wdata_r  <= 32'h00000000;
            be_r     <= 4'b0000;
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
        end else begin
            case (state_r)
                MEM_IDLE: begin
                    if (req_op_s && !dmem_ack) begin
                        state_r  <= MEM_WAIT;
                        addr_r   <= ALU_in_MEM;
                        wdata_r  <= in_wdata_s;
                        be_r     <= in_be_s;
                        we_r     <= MemWrite_in_MEM;
                        funct3_r <= Funct3_in_MEM;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_r <= MEM_IDLE;
                    end
                end
                default: state_r <= MEM_IDLE;
            endcase
        end
    end

    // MEM/WB pipeline register; a stall cycle becomes a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out_WB    <= 1'b0;
            RegWrite_out_WB <= 1'b0;
            debug_out_WB    <= '0;
            PC4_out_WB      <= 32'h00000000;
            ALU_out_WB      <= 32'h00000000;
            DMem_data_WB    <= 32'h00000000;
            MemtoReg_out_WB <= 2'b00;
            Rd_out_WB       <= 5'b00000;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_WB     <= 1'b0;
`endif
        end else if (!stall_MEM) begin
            valid_out_WB    <= valid_in_MEM;
            RegWrite_out_WB <= RegWrite_in_MEM & ~misalign_s;
            debug_out_WB    <= debug_in_MEM;
            PC4_out_WB      <= PC4_in_MEM;
            ALU_out_WB      <= ALU_in_MEM;
            DMem_data_WB    <= ld_data_s;
            MemtoReg_out_WB <= MemtoReg_in_MEM;
            Rd_out_WB       <= Rd_in_MEM;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_WB     <= misalign_s;
`endif
        end else begin
            valid_out_WB    <= 1'b0;
            RegWrite_out_WB <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_WB     <= 1'b0;
`endif
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'h00000000;
        end else if (stall_MEM && (stall_cycles != 32'hFFFFFFFF)) begin
            stall_cycles <= stall_cycles + 32'h00000001;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Scoreboard bench for pipeline_mem_stage: byte-level reference memory, randomized
// loads/stores with random memory latency, plus directed alignment and reset cases.
module tb_pipeline_mem_stage;
    import pcpu::*;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in_MEM;
    Debug_t      debug_in_MEM;
    logic [31:0] PC4_in_MEM, ALU_in_MEM, Data_in_MEM;
    logic        MemRead_in_MEM, MemWrite_in_MEM;
    logic [2:0]  Funct3_in_MEM;
    logic [1:0]  MemtoReg_in_MEM;
    logic        RegWrite_in_MEM;
    logic [4:0]  Rd_in_MEM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_MEM, valid_out_WB, RegWrite_out_WB;
    Debug_t      debug_out_WB;
    logic [31:0] PC4_out_WB, ALU_out_WB, DMem_data_WB, stall_cycles;
    logic [1:0]  MemtoReg_out_WB;
    logic [4:0]  Rd_out_WB;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_WB;
`endif

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] data;
        Debug_t      dbg;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  m2r;
        bit          is_load;
        bit          mis;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall = 32'h0;
    logic [7:0]  refmem  [0:255];
    logic [31:0] bus_mem [0:63];

    pipeline_mem_stage dut (
        .clk(clk), .rst(rst), .valid_in_MEM(valid_in_MEM), .debug_in_MEM(debug_in_MEM),
        .PC4_in_MEM(PC4_in_MEM), .ALU_in_MEM(ALU_in_MEM), .Data_in_MEM(Data_in_MEM),
        .MemRead_in_MEM(MemRead_in_MEM), .MemWrite_in_MEM(MemWrite_in_MEM),
        .Funct3_in_MEM(Funct3_in_MEM), .MemtoReg_in_MEM(MemtoReg_in_MEM),
        .RegWrite_in_MEM(RegWrite_in_MEM), .Rd_in_MEM(Rd_in_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_MEM(stall_MEM), .valid_out_WB(valid_out_WB),
        .RegWrite_out_WB(RegWrite_out_WB), .debug_out_WB(debug_out_WB),
        .PC4_out_WB(PC4_out_WB), .ALU_out_WB(ALU_out_WB), .DMem_data_WB(DMem_data_WB),
        .MemtoReg_out_WB(MemtoReg_out_WB), .Rd_out_WB(Rd_out_WB),
        .stall_cycles(stall_cycles)
`ifdef MEM_ALIGN_CHECK_EN
        , .misalign_WB(misalign_WB)
`endif
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT: combinational read of the addressed word.
    assign dmem_rdata = bus_mem[dmem_addr[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        int idx = int'(a[7:2]);
        bus_mem[idx] = w;
        for (int j = 0; j < 4; j++) refmem[4 * idx + j] = w[8 * j +: 8];
    endtask

    // Reference load: read bytes from the byte memory and extend with signed casts.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int b = int'(a[7:0]);
        int h = b - (b % 2);
        int w = b - (b % 4);
        case (f3)
            3'b000:  return 32'($signed(refmem[b]));
            3'b100:  return 32'(refmem[b]);
            3'b001:  return 32'($signed({refmem[h + 1], refmem[h]}));
            3'b101:  return 32'({refmem[h + 1], refmem[h]});
            default: return {refmem[w + 3], refmem[w + 2], refmem[w + 1], refmem[w]};
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rs2);
        int b = int'(a[7:0]);
        int n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        int base = b - (b % n);
        for (int j = 0; j < n; j++) refmem[base + j] = rs2[8 * j +: 8];
    endtask

    // Issue one instruction, serve it with 'lat' wait cycles and check the bus each cycle.
    task automatic do_instr(input bit v, input bit rd_op, input bit wr_op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2, input int lat,
                            input bit spur_ack);
        bit          mem, mis, req;
        int          b;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        exp_t        e;
        mem = v && (rd_op || wr_op);
        mis = ALIGN_EN && mem && ((((f3 == 3'b001) || (f3 == 3'b101)) && addr[0]) ||
                                  ((f3 == 3'b010) && (addr[1:0] != 2'b00)));
        req = mem && !mis;
        if (!req) lat = 0;
        b = int'(addr[1:0]);
        exp_be = 4'hF;
        exp_wd = rs2;
        if (wr_op && f3 == 3'b000) begin
            exp_be = 4'(1 << b);
            exp_wd = 32'(rs2[7:0]) * 32'h01010101;
        end else if (wr_op && f3 == 3'b001) begin
            exp_be = (b >= 2) ? 4'b1100 : 4'b0011;
            exp_wd = 32'(rs2[15:0]) * 32'h00010001;
        end
        e.pc4 = $urandom();
        e.alu = addr;
        e.data = ref_load(f3, addr);
        e.dbg.pc = $urandom();
        e.dbg.instr = $urandom();
        e.rd = 5'($urandom_range(0, 31));
        e.m2r = 2'($urandom_range(0, 3));
        e.rw = v ? 1'($urandom_range(0, 1)) : 1'b0;
        e.is_load = rd_op;
        e.mis = mis;
        if (req && wr_op) ref_store(f3, addr, rs2);

        valid_in_MEM = v;  debug_in_MEM = e.dbg;  PC4_in_MEM = e.pc4;  ALU_in_MEM = addr;
        Data_in_MEM = rs2; MemRead_in_MEM = rd_op; MemWrite_in_MEM = wr_op;
        Funct3_in_MEM = f3; MemtoReg_in_MEM = e.m2r; RegWrite_in_MEM = e.rw; Rd_in_MEM = e.rd;
        if (mis) e.rw = 1'b0;
        if (v) sb.push_back(e);

        for (int k = 0; k <= lat; k++) begin
            dmem_ack = req ? (k == lat) : spur_ack;
            @(negedge clk);
            chk1("dmem_req", dmem_req, req);
            chk1("stall_MEM", stall_MEM, req && (k < lat));
            if (req) begin
                chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
                chk("dmem_be", 32'(dmem_be), 32'(exp_be));
                chk1("dmem_we", dmem_we, wr_op);
                if (wr_op) chk("dmem_wdata", dmem_wdata, exp_wd);
            end
            if (k > 0) begin
                chk1("bubble_valid", valid_out_WB, 1'b0);
                chk1("bubble_regwrite", RegWrite_out_WB, 1'b0);
            end
            if (dmem_req && dmem_ack && dmem_we) begin
                for (int j = 0; j < 4; j++)
                    if (dmem_be[j]) bus_mem[dmem_addr[7:2]][8 * j +: 8] = dmem_wdata[8 * j +: 8];
            end
            @(posedge clk);
            #1;
        end
        exp_stall = exp_stall + 32'(lat);
        dmem_ack = 1'b0;
    endtask

    // Monitor: every valid WB output is matched against the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t m;
        if (!rst && valid_out_WB) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected actual=valid expected=none pc4=0x%08h", PC4_out_WB);
            end else begin
                m = sb.pop_front();
                chk("wb_pc4", PC4_out_WB, m.pc4);
                chk("wb_alu", ALU_out_WB, m.alu);
                chk("wb_dbg_pc", debug_out_WB.pc, m.dbg.pc);
                chk("wb_dbg_instr", debug_out_WB.instr, m.dbg.instr);
                chk("wb_rd", 32'(Rd_out_WB), 32'(m.rd));
                chk("wb_memtoreg", 32'(MemtoReg_out_WB), 32'(m.m2r));
                chk1("wb_regwrite", RegWrite_out_WB, m.rw);
`ifdef MEM_ALIGN_CHECK_EN
                chk1("wb_misalign", misalign_WB, m.mis);
`endif
                if (m.is_load && !m.mis) chk("wb_load_data", DMem_data_WB, m.data);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] ra, rd2;
        int          op;
        rst = 1'b1; dmem_ack = 1'b0; valid_in_MEM = 1'b0; debug_in_MEM = '0;
        PC4_in_MEM = 32'h0; ALU_in_MEM = 32'h0; Data_in_MEM = 32'h0;
        MemRead_in_MEM = 1'b0; MemWrite_in_MEM = 1'b0; Funct3_in_MEM = 3'b000;
        MemtoReg_in_MEM = 2'b00; RegWrite_in_MEM = 1'b0; Rd_in_MEM = 5'd0;
        for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom());
        #12;
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_stall", stall_MEM, 1'b0);
        chk1("rst_valid", valid_out_WB, 1'b0);
        chk("rst_data", DMem_data_WB, 32'h0);
        chk("rst_stall_cycles", stall_cycles, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        set_word(32'h100, 32'hDEADBEEF);
        do_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
        chk("lw_data", DMem_data_WB, 32'hDEADBEEF);
        chk1("lw_valid", valid_out_WB, 1'b1);
        set_word(32'h100, 32'h80FF0011);
        do_instr(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b0);
        chk("lb_data", DMem_data_WB, 32'hFFFFFF80);
        do_instr(1'b1, 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 1'b0);
        chk("lbu_data", DMem_data_WB, 32'h00000080);
        do_instr(1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 1'b0);
        chk("lhu_data", DMem_data_WB, 32'h000080FF);
        do_instr(1'b1, 1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 0, 1'b0);
        do_instr(1'b1, 1'b0, 1'b1, 3'b010, 32'h204, 32'h12345678, 3, 1'b0);
        chk("sw_stall_cycles", stall_cycles, exp_stall);
        do_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 0, 1'b0);
        chk("sw_readback", DMem_data_WB, 32'h12345678);
`ifdef MEM_ALIGN_CHECK_EN
        do_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 2, 1'b0);
        chk1("mis_flag", misalign_WB, 1'b1);
        chk1("mis_regwrite", RegWrite_out_WB, 1'b0);
`endif

        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 5);
            ra = $urandom();
            rd2 = $urandom();
            case (op)
                0: do_instr(1'b0, 1'($urandom_range(0, 1)), 1'b0, 3'b010, ra, rd2, 0,
                            1'($urandom_range(0, 1)));
                1: do_instr(1'b1, 1'b0, 1'b0, 3'b010, ra, rd2, 0, 1'($urandom_range(0, 1)));
                2, 3: do_instr(1'b1, 1'b1, 1'b0, ld_f3[$urandom_range(0, 4)], ra, rd2,
                               $urandom_range(0, 3), 1'b0);
                default: do_instr(1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 2)), ra, rd2,
                                  $urandom_range(0, 3), 1'b0);
            endcase
        end
        chk("rand_stall_cycles", stall_cycles, exp_stall);

        // Reset while the stage is waiting on memory.
        valid_in_MEM = 1'b1; MemRead_in_MEM = 1'b1; MemWrite_in_MEM = 1'b0;
        Funct3_in_MEM = 3'b010; ALU_in_MEM = 32'h40; RegWrite_in_MEM = 1'b1;
        PC4_in_MEM = 32'h00000444;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk1("wait_stall", stall_MEM, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("wait_req", dmem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("rstwait_req", dmem_req, 1'b0);
        chk1("rstwait_stall", stall_MEM, 1'b0);
        chk1("rstwait_valid", valid_out_WB, 1'b0);
        chk1("rstwait_regwrite", RegWrite_out_WB, 1'b0);
        chk("rstwait_pc4", PC4_out_WB, 32'h0);
        chk("rstwait_stall_cycles", stall_cycles, 32'h0);
        valid_in_MEM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_stall = 32'h0;
        @(negedge clk);
        chk1("post_rst_req", dmem_req, 1'b0);
        @(posedge clk); #1;
        do_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 0, 1'b0);
        do_instr(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 0, 1'b0);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("final_stall_cycles", stall_cycles, exp_stall);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
